// File: rtl/fft_butterfly_2_if.sv
// Butterfly operand/result bundle: pair + twiddle in, two results and status out.
interface fft_butterfly_2_if #(
  parameter int unsigned Q_IN   = 15,
  parameter int unsigned Q_COEF = 15,
  parameter int unsigned Q_OUT  = 15
);
  logic                valid_in;
  logic signed [Q_IN:0]   data_in_real_0;
  logic signed [Q_IN:0]   data_in_imag_0;
  logic signed [Q_IN:0]   data_in_real_1;
  logic signed [Q_IN:0]   data_in_imag_1;
  logic signed [Q_COEF:0] coeff_in_real;
  logic signed [Q_COEF:0] coeff_in_imag;

  logic                valid_out;
  logic signed [Q_OUT:0]  data_out_real_0;
  logic signed [Q_OUT:0]  data_out_imag_0;
  logic signed [Q_OUT:0]  data_out_real_1;
  logic signed [Q_OUT:0]  data_out_imag_1;
  logic                frame_done;
  logic                ovf;

  // Butterfly side: consumes operands, produces results.
  modport slave (
    input  valid_in, data_in_real_0, data_in_imag_0, data_in_real_1, data_in_imag_1,
           coeff_in_real, coeff_in_imag,
    output valid_out, data_out_real_0, data_out_imag_0, data_out_real_1, data_out_imag_1,
           frame_done, ovf
  );

  // Upstream/driver side.
  modport master (
    output valid_in, data_in_real_0, data_in_imag_0, data_in_real_1, data_in_imag_1,
           coeff_in_real, coeff_in_imag,
    input  valid_out, data_out_real_0, data_out_imag_0, data_out_real_1, data_out_imag_1,
           frame_done, ovf
  );
endinterface

// File: rtl/fft_butterfly_2.sv
// Pipelined radix-2 DIT butterfly: a +/- W*b with single rounding, optional
// halving, saturation, per-stage butterfly counting and sticky overflow.
// Interface widths must match Q_IN/Q_COEF/Q_OUT of this module.
module fft_butterfly_2 #(
  parameter int unsigned Q_IN   = 15,
  parameter int unsigned Q_COEF = 15,
  parameter int unsigned Q_OUT  = 15,
  parameter int unsigned N      = 8,
  parameter int unsigned SCALE  = 0
) (
  input  logic              clk,
  input  logic              reset,
  fft_butterfly_2_if.slave  bus
);

  localparam int unsigned IW    = Q_IN + 1;
  localparam int unsigned WW    = Q_COEF + 1;
  localparam int unsigned OW    = Q_OUT + 1;
  localparam int unsigned PW    = Q_IN + Q_COEF + 3;
  localparam int unsigned TW    = Q_IN + 3;
  localparam int unsigned SW    = (TW > OW + 1) ? TW : OW + 1;
  localparam int unsigned HALF  = N / 2;
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(HALF - 1);
  localparam logic signed [PW-1:0] RND     = PW'(1) <<< (Q_COEF - 1);
  localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< Q_OUT) - SW'(1);
  localparam logic signed [SW-1:0] SAT_MIN = -(SW'(1) <<< Q_OUT);

  // S1 registers
  logic                 s1_valid;
  logic signed [IW-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
  logic signed [WW-1:0] s1_w_re, s1_w_im;

  // S2 registers
  logic                 s2_valid;
  logic signed [IW-1:0] s2_a_re, s2_a_im;
  logic signed [TW-1:0] s2_t_re, s2_t_im;

  logic [CNT_W-1:0]     bfly_cnt;

  // S2 combinational product
  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, prod_re, prod_im;
  logic signed [TW-1:0] t_re_c, t_im_c;

  // S3 combinational add/sub/scale/saturate
  logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic [OW:0]          sat_re0, sat_im0, sat_re1, sat_im1;
  logic                 clamp_c;

  // Clamp to output range; MSB of the result flags a clamp.
  function automatic logic [OW:0] sat(input logic signed [SW-1:0] x);
    if (x > SAT_MAX)      return {1'b1, OW'(SAT_MAX)};
    else if (x < SAT_MIN) return {1'b1, OW'(SAT_MIN)};
    else                  return {1'b0, OW'(x)};
  endfunction

  // Input capture stage
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_b_re  <= '0;
      s1_b_im  <= '0;
      s1_w_re  <= '0;
      s1_w_im  <= '0;
    end else begin
      s1_valid <= bus.valid_in;
      if (bus.valid_in) begin
        s1_a_re <= bus.data_in_real_0;
        s1_a_im <= bus.data_in_imag_0;
        s1_b_re <= bus.data_in_real_1;
        s1_b_im <= bus.data_in_imag_1;
        s1_w_re <= bus.coeff_in_real;
        s1_w_im <= bus.coeff_in_imag;
      end
    end
  end

  // Full-precision complex product W*b, rounded half-up once at Q_COEF
  always_comb begin
    br_x    = PW'(s1_b_re);
    bi_x    = PW'(s1_b_im);
    wr_x    = PW'(s1_w_re);
    wi_x    = PW'(s1_w_im);
    prod_re = br_x * wr_x - bi_x * wi_x + RND;
    prod_im = br_x * wi_x + bi_x * wr_x + RND;
    t_re_c  = TW'(prod_re >>> Q_COEF);
    t_im_c  = TW'(prod_im >>> Q_COEF);
  end

  // Product stage, carrying a alongside t
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_a_re  <= '0;
      s2_a_im  <= '0;
      s2_t_re  <= '0;
      s2_t_im  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_a_re <= s1_a_re;
        s2_a_im <= s1_a_im;
        s2_t_re <= t_re_c;
        s2_t_im <= t_im_c;
      end
    end
  end

  // a +/- t, optional rounded halving, then saturation
  always_comb begin
    sum_re = SW'(s2_a_re) + SW'(s2_t_re);
    sum_im = SW'(s2_a_im) + SW'(s2_t_im);
    dif_re = SW'(s2_a_re) - SW'(s2_t_re);
    dif_im = SW'(s2_a_im) - SW'(s2_t_im);
    if (SCALE == 1) begin
      sum_re = (sum_re + SW'(1)) >>> 1;
      sum_im = (sum_im + SW'(1)) >>> 1;
      dif_re = (dif_re + SW'(1)) >>> 1;
      dif_im = (dif_im + SW'(1)) >>> 1;
    end
    sat_re0 = sat(sum_re);
    sat_im0 = sat(sum_im);
    sat_re1 = sat(dif_re);
    sat_im1 = sat(dif_im);
    clamp_c = sat_re0[OW] | sat_im0[OW] | sat_re1[OW] | sat_im1[OW];
  end

  // Output stage: results hold between strobes, overflow is sticky
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid_out       <= 1'b0;
      bus.data_out_real_0 <= '0;
      bus.data_out_imag_0 <= '0;
      bus.data_out_real_1 <= '0;
      bus.data_out_imag_1 <= '0;
      bus.ovf             <= 1'b0;
    end else begin
      bus.valid_out <= s2_valid;
      if (s2_valid) begin
        bus.data_out_real_0 <= sat_re0[OW-1:0];
        bus.data_out_imag_0 <= sat_im0[OW-1:0];
        bus.data_out_real_1 <= sat_re1[OW-1:0];
        bus.data_out_imag_1 <= sat_im1[OW-1:0];
        if (clamp_c) bus.ovf <= 1'b1;
      end
    end
  end

  // Butterflies-per-stage counter; frame_done rides with the last result
  always_ff @(posedge clk) begin
    if (reset) begin
      bfly_cnt       <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= s2_valid && (bfly_cnt == CNT_LAST);
      if (s2_valid) begin
        bfly_cnt <= (bfly_cnt == CNT_LAST) ? '0 : bfly_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly_2.sv
// Directed bench for fft_butterfly_2: SCALE=0 and SCALE=1 instances share stimulus.
module tb_fft_butterfly_2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_butterfly_2_if #(.Q_IN(15), .Q_COEF(15), .Q_OUT(15)) bus0 ();
  fft_butterfly_2_if #(.Q_IN(15), .Q_COEF(15), .Q_OUT(15)) bus1 ();

  fft_butterfly_2 #(.Q_IN(15), .Q_COEF(15), .Q_OUT(15), .N(8), .SCALE(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  fft_butterfly_2 #(.Q_IN(15), .Q_COEF(15), .Q_OUT(15), .N(8), .SCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, sampled at the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ar, input logic [15:0] ai,
                       input logic [15:0] br, input logic [15:0] bi,
                       input logic [15:0] wr, input logic [15:0] wi);
    bus0.data_in_real_0 = ar; bus1.data_in_real_0 = ar;
    bus0.data_in_imag_0 = ai; bus1.data_in_imag_0 = ai;
    bus0.data_in_real_1 = br; bus1.data_in_real_1 = br;
    bus0.data_in_imag_1 = bi; bus1.data_in_imag_1 = bi;
    bus0.coeff_in_real  = wr; bus1.coeff_in_real  = wr;
    bus0.coeff_in_imag  = wi; bus1.coeff_in_imag  = wi;
  endtask

  task automatic set_valid(input logic v);
    bus0.valid_in = v;
    bus1.valid_in = v;
  endtask

  // One isolated pair; returns just after edge k+2 where results are visible.
  task automatic apply_pair(input logic [15:0] ar, input logic [15:0] ai,
                            input logic [15:0] br, input logic [15:0] bi,
                            input logic [15:0] wr, input logic [15:0] wi);
    drive(ar, ai, br, bi, wr, wi);
    set_valid(1'b1);
    step();
    set_valid(1'b0);
    step();
    check("vo_k1", 16'(bus0.valid_out), 16'h0);
    step();
    check("vo_k2", 16'(bus0.valid_out), 16'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_valid(1'b0);
    drive(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_vo",   16'(bus0.valid_out),  16'h0);
    check("rst_re0",  bus0.data_out_real_0, 16'h0);
    check("rst_im1",  bus0.data_out_imag_1, 16'h0);
    check("rst_fd",   16'(bus0.frame_done), 16'h0);
    check("rst_ovf",  16'(bus0.ovf),        16'h0);

    // Identity twiddle (butterfly 1 of stage)
    apply_pair(16'h4000, 16'h0, 16'h2000, 16'h0, 16'h7FFF, 16'h0);
    check("id_re0", bus0.data_out_real_0, 16'h6000);
    check("id_im0", bus0.data_out_imag_0, 16'h0000);
    check("id_re1", bus0.data_out_real_1, 16'h2000);
    check("id_im1", bus0.data_out_imag_1, 16'h0000);
    check("id_ovf", 16'(bus0.ovf),        16'h0);
    check("id_fd",  16'(bus0.frame_done), 16'h0);
    step();
    check("id_strobe", 16'(bus0.valid_out),  16'h0);
    check("id_hold",   bus0.data_out_real_0, 16'h6000);

    // -j twiddle (butterfly 2)
    apply_pair(16'h4000, 16'h0, 16'h2000, 16'h0, 16'h0000, 16'h8000);
    check("mj_re0", bus0.data_out_real_0, 16'h4000);
    check("mj_im0", bus0.data_out_imag_0, 16'hE000);
    check("mj_re1", bus0.data_out_real_1, 16'h4000);
    check("mj_im1", bus0.data_out_imag_1, 16'h2000);

    // Saturation (butterfly 3): clamp without scaling, fits with scaling
    apply_pair(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0);
    check("sat0_re0", bus0.data_out_real_0, 16'h7FFF);
    check("sat0_re1", bus0.data_out_real_1, 16'h0001);
    check("sat0_ovf", 16'(bus0.ovf),        16'h1);
    check("sat1_re0", bus1.data_out_real_0, 16'h7FFF);
    check("sat1_re1", bus1.data_out_real_1, 16'h0001);
    check("sat1_im0", bus1.data_out_imag_0, 16'h0000);
    check("sat1_ovf", 16'(bus1.ovf),        16'h0);

    // Clean pair (butterfly 4): ovf sticky, frame_done on last butterfly
    apply_pair(16'h4000, 16'h0, 16'h2000, 16'h0, 16'h7FFF, 16'h0);
    check("clean_re0",  bus0.data_out_real_0, 16'h6000);
    check("clean_ovf0", 16'(bus0.ovf),        16'h1);
    check("clean_ovf1", 16'(bus1.ovf),        16'h0);
    check("clean_sc_re0", bus1.data_out_real_0, 16'h3000);
    check("clean_fd",   16'(bus0.frame_done), 16'h1);
    step();
    check("clean_fd_drop", 16'(bus0.frame_done), 16'h0);

    // Back-to-back frame of 8 pairs; out0 = a since b = 0
    for (int i = 0; i < 11; i++) begin
      drive(16'(i * 256), 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0);
      set_valid(i < 8);
      step();
      begin
        logic evo, efd;
        evo = (i >= 2) && (i < 10);
        efd = evo && (((i - 2) % 4) == 3);
        check("b2b_vo", 16'(bus0.valid_out),  16'(evo));
        check("b2b_fd", 16'(bus0.frame_done), 16'(efd));
        if (evo) check("b2b_re0", bus0.data_out_real_0, 16'((i - 2) * 256));
      end
    end

    // Upstream cadence: one pair every 3 cycles
    for (int i = 0; i < 26; i++) begin
      drive(16'(i * 16), 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0);
      set_valid((i % 3 == 0) && (i < 24));
      step();
      begin
        logic evo, efd;
        evo = (i >= 2) && (((i - 2) % 3) == 0) && (((i - 2) / 3) < 8);
        efd = evo && ((((i - 2) / 3) % 4) == 3);
        check("cad_vo", 16'(bus0.valid_out),  16'(evo));
        check("cad_fd", 16'(bus0.frame_done), 16'(efd));
      end
    end

    // Leave the counter at 1, then reset with a pair in flight
    apply_pair(16'h4000, 16'h0, 16'h2000, 16'h0, 16'h7FFF, 16'h0);
    drive(16'h1234, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0);
    set_valid(1'b1);
    step();
    set_valid(1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("mid_vo",  16'(bus0.valid_out),  16'h0);
    check("mid_re0", bus0.data_out_real_0, 16'h0);
    check("mid_re1", bus0.data_out_real_1, 16'h0);
    check("mid_ovf", 16'(bus0.ovf),        16'h0);
    check("mid_fd",  16'(bus0.frame_done), 16'h0);

    // valid_in together with reset: pair dropped
    set_valid(1'b1);
    reset = 1'b1;
    step();
    set_valid(1'b0);
    reset = 1'b0;
    step();
    step();
    check("rstv_vo", 16'(bus0.valid_out), 16'h0);

    // Counter restarts at 0: frame_done only on the 4th pair after reset
    for (int j = 0; j < 4; j++) begin
      apply_pair(16'h4000, 16'h0, 16'h2000, 16'h0, 16'h7FFF, 16'h0);
      check("post_re0", bus0.data_out_real_0, 16'h6000);
      check("post_re1", bus0.data_out_real_1, 16'h2000);
      check("post_fd",  16'(bus0.frame_done), 16'(j == 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_butterfly_2.md
# fft_butterfly_2

Pipelined radix-2 decimation-in-time butterfly that consumes the reordered sample pairs and twiddle coefficients emitted by `fft_stage_2`. For each accepted pair (a, b) and twiddle W it computes a + W·b and a − W·b with single-point rounding, optional 1-bit scaling and saturation. It counts butterflies per FFT stage and flags saturation events. It sits directly downstream of `fft_stage_2` in the `frame_fft_block` datapath.

## Interface
- `Q_IN`, default 15: input sample MSB index; samples are Q_IN+1 bits, signed Q1.Q_IN.
- `Q_COEF`, default 15: twiddle MSB index; coefficients are Q_COEF+1 bits, signed Q1.Q_COEF.
- `Q_OUT`, default 15: output MSB index; outputs are Q_OUT+1 bits, signed.
- `N`, default 8: FFT points; one stage contains N/2 butterflies.
- `SCALE`, default 0: 1 means divide both results by 2 (rounded) before saturation.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_in` in 1: input pair and coefficient valid this cycle.
- `data_in_real_0`, `data_in_imag_0` in Q_IN+1 signed: operand a.
- `data_in_real_1`, `data_in_imag_1` in Q_IN+1 signed: operand b.
- `coeff_in_real`, `coeff_in_imag` in Q_COEF+1 signed: twiddle W.
- `valid_out` out 1: one-cycle strobe marking a new result.
- `data_out_real_0`, `data_out_imag_0` out Q_OUT+1 signed: a + W·b.
- `data_out_real_1`, `data_out_imag_1` out Q_OUT+1 signed: a − W·b.
- `frame_done` out 1: pulses with the `valid_out` of the (N/2)-th butterfly of a stage.
- `ovf` out 1: sticky flag, set on any output saturation; cleared only by reset.

## Operation
- No back-pressure. The block accepts `valid_in` on every cycle, either back-to-back or sparse (the upstream sends one pair per 3 cycles).
- Pipeline S1: register a, b and W, plus the valid bit.
- Pipeline S2: compute the full-precision complex product.
  - t_re = br·wr − bi·wi and t_im = br·wi + bi·wr, each held in a Q_IN+Q_COEF+3-bit sum.
  - Round once: add 2^(Q_COEF−1), then arithmetic shift right by Q_COEF. The result is floor-based round-half-up.
  - Register t together with a delayed copy of a.
- Pipeline S3: compute sum = a + t and diff = a − t in Q_IN+3 bits.
  - If SCALE=1, each result becomes (x + 1) >>> 1.
  - Saturate each result to [−2^Q_OUT, 2^Q_OUT − 1]. Any clamp sets `ovf`.
  - Register the results into the data outputs and drive `valid_out`.
- A coefficient of −2^Q_COEF represents exactly −1. +1 is not representable; the upstream supplies 2^Q_COEF − 1.
- Butterfly counter: a log2(N/2)-bit counter increments on each `valid_out`.
  - `frame_done` = `valid_out` AND (counter == N/2 − 1).
  - The counter wraps to 0 after the last butterfly of a stage.
- Data outputs hold their last value while `valid_out` is 0.

## Timing
- Latency: with `valid_in` sampled at edge k, outputs and `valid_out` update at edge k+2. There are 3 register stages (S1, S2, S3).
- Throughput: one butterfly per clock. `valid_out` mirrors the `valid_in` pattern, delayed by 2 edges.
- Reset values: `valid_out`=0, all data outputs=0, `frame_done`=0, `ovf`=0, butterfly counter=0, all pipeline valid bits=0.
- Reset mid-operation clears all pipeline valid bits. No `valid_out` is produced for pairs in flight, and the counter restarts at 0.
- When `valid_in` and reset are high in the same cycle, reset wins and the pair is dropped.
- Counter wrap and a new stage's first butterfly can occur on consecutive cycles with no bubble.
- `ovf` can set on the same edge as `valid_out` and stays set until reset.

## Test plan
- Identity twiddle, SCALE=0: a=(0x4000,0), b=(0x2000,0), W=(0x7FFF,0).
  - Expect out0=(0x6000,0) and out1=(0x2000,0).
  - `valid_out` rises 2 edges after input and lasts 1 cycle. `ovf`=0.
- −j twiddle: a=(0x4000,0), b=(0x2000,0), W=(0,0x8000).
  - Expect out0=(0x4000,0xE000) and out1=(0x4000,0x2000).
- Saturation, SCALE=0: a=b=(0x7FFF,0), W=(0x7FFF,0), giving t_re=0x7FFE.
  - Expect out0_re=0x7FFF (clamped) and out1_re=0x0001. `ovf`=1 and stays 1 after further clean inputs.
- Same vectors with SCALE=1.
  - Expect out0_re=0x7FFF (not clamped) and out1_re=0x0001. `ovf` stays 0.
- Frame accounting, N=8: drive 8 back-to-back valid pairs.
  - Expect 8 consecutive `valid_out` pulses.
  - `frame_done` is high on the 4th and 8th `valid_out` only.
  - Repeat with the upstream 1-in-3 cadence: same pulse pattern, spaced 3 cycles apart.
- Reset mid-pipeline: `valid_in` at edge k, reset high at edge k+1.
  - Expect no `valid_out` at edge k+2. Outputs, `ovf` and the counter read 0.
  - The next pair after reset yields a normal result with counter = 0.
